clk_gate_ctrl: RTL and testbench
================================

// Module: clk_gate_ctrl
// PURPOSE
//  Auto clock-gating controller: owns the enable side of one tc_clk_gating cell
//  and delivers the gated clock clk_o to a peripheral/accelerator domain.
//  Gates the clock after a programmable run of idle cycles. Ungates on wake
//  request or busy, then signals "clock running" back to the requester.
//  Runs on the free-running clock; gate_en_o is registered (glitch-free into the ICG latch).
// PARAMETERS
//  IDLE_CNT_W  8   width of idle counter and idle_thresh_i
//  WAKE_LAT    2   cycles in WAKING before ack; legal range 1..15
//  EVT_CNT_W   16  width of gate-event counter
// PORTS
//  clk_i          in   1           free-running clock
//  rst_ni         in   1           async reset, active low
//  test_en_i      in   1           scan: drives ICG TE, forces clk_o running; FSM unaffected
//  auto_gate_en_i in   1           1 = auto gating allowed
//  sw_force_on_i  in   1           1 = keep clock on, overrides auto gating
//  idle_thresh_i  in   IDLE_CNT_W  gate after idle_thresh_i+1 consecutive idle cycles
//  busy_i         in   1           domain busy; counts as non-idle, wakes when gated
//  wake_req_i     in   1           level wake request, held until wake_ack_o=1
//  wake_ack_o     out  1           1 = state ON (clock running and settled)
//  gate_en_o      out  1           registered ICG enable (observability)
//  clk_o          out  1           gated clock = tc_clk_gating(clk_i, gate_en_o, test_en_i)
//  evt_clr_i      in   1           sync clear of evt_cnt_o
//  evt_cnt_o      out  EVT_CNT_W   number of ON->GATED transitions, saturating
// BEHAVIOUR
//  Reset: state=ON, gate_en_o=1, wake_ack_o=1, idle_cnt=0, wake_cnt=0, evt_cnt_o=0.
//  idle  = auto_gate_en_i & ~sw_force_on_i & ~busy_i & ~wake_req_i.
//  wake  = ~idle.
//  FSM states: ON, GATED, WAKING. All outputs are decoded from flops.
//  ON: gate_en_o=1, wake_ack_o=1.
//   - wake: idle_cnt<=0.
//   - idle and idle_cnt >= idle_thresh_i: ->GATED; idle_cnt<=0; evt_cnt+1.
//   - otherwise idle: idle_cnt+1, saturating at all-ones.
//   - Threshold is compared live; lowering it below idle_cnt gates at the next idle cycle.
//  GATED: gate_en_o=0, wake_ack_o=0.
//   - wake: ->WAKING; wake_cnt<=WAKE_LAT-1.
//  WAKING: gate_en_o=1, wake_ack_o=0.
//   - wake_cnt==0: ->ON; otherwise wake_cnt-1.
//   - Always completes regardless of idle: no abort back to GATED.
//  Latency:
//   - wake sampled in GATED at edge n: gate_en_o=1 after n, wake_ack_o=1 after n+WAKE_LAT.
//   - Idle run from thresh=T: gate_en_o falls after the (T+1)th consecutive idle edge.
//  Handshake: 4-phase.
//   - Requester raises wake_req_i and holds it until wake_ack_o=1.
//   - Requester may drop it afterwards; the idle count restarts from 0.
//   - wake_req_i high while in ON: no state change, idle_cnt held at 0.
//  evt_cnt_o:
//   - Saturates at all-ones.
//   - evt_clr_i has priority over a same-cycle increment; the result is 0.
//  Reset mid-WAKING or mid-GATED: asynchronous return to ON, clock enabled immediately.
//  test_en_i=1: clk_o toggles regardless of gate_en_o; FSM and counters behave normally.
// TESTING
//  1. T=3, auto=1, busy=0, req=0 from reset:
//     gate_en_o falls after the 4th idle edge; evt_cnt_o=1; clk_o stops.
//  2. GATED, pulse wake_req_i high at edge n, WAKE_LAT=2:
//     gate_en_o=1 after n; wake_ack_o=1 after n+2; clk_o resumes with no glitch.
//  3. ON, T=5, busy_i toggles 1 every 4th cycle:
//     never gates; idle_cnt max 3; evt_cnt_o stays 0.
//  4. sw_force_on_i=1 while GATED: ->WAKING->ON.
//     Then sw_force_on_i=0: gates again after T+1 idle cycles.
//  5. evt_cnt_o=0xFFFF: a further gate event holds 0xFFFF.
//     evt_clr_i on the same edge as a gate event -> evt_cnt_o=0.
//  6. rst_ni low mid-WAKING: gate_en_o=1 and wake_ack_o=1 asynchronously.
//     test_en_i=1 while GATED: clk_o toggles and state stays GATED.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl
//   Auto clock-gating controller. It owns the enable side of one integrated
//   clock-gating cell and delivers the gated clock clk_o to a downstream
//   domain. The clock is gated after a programmable run of idle cycles and
//   ungated on a wake request or on busy. Once the clock is running and has
//   settled, wake_ack_o tells the requester.
//
// Parameters
//   IDLE_CNT_W  width of the idle counter and of idle_thresh_i
//   WAKE_LAT    cycles spent in WAKING before ack (legal range 1..15)
//   EVT_CNT_W   width of the saturating gate-event counter
//
// Ports
//   clk_i          free-running clock
//   rst_ni         asynchronous reset, active low
//   test_en_i      scan enable; forces clk_o running, FSM unaffected
//   auto_gate_en_i 1 = auto gating allowed
//   sw_force_on_i  1 = keep clock on, overrides auto gating
//   idle_thresh_i  gate after idle_thresh_i+1 consecutive idle cycles
//   busy_i         domain busy; non-idle, wakes the clock when gated
//   wake_req_i     level wake request, held until wake_ack_o=1
//   wake_ack_o     1 = clock running and settled (state ON)
//   gate_en_o      registered ICG enable
//   clk_o          gated clock
//   evt_clr_i      synchronous clear of evt_cnt_o
//   evt_cnt_o      number of ON->GATED transitions, saturating
// -----------------------------------------------------------------------------
module clk_gate_ctrl #(
    parameter int IDLE_CNT_W = 8,
    parameter int WAKE_LAT   = 2,
    parameter int EVT_CNT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_en_i,
    input  logic                  auto_gate_en_i,
    input  logic                  sw_force_on_i,
    input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
    input  logic                  busy_i,
    input  logic                  wake_req_i,
    output logic                  wake_ack_o,
    output logic                  gate_en_o,
    output logic                  clk_o,
    input  logic                  evt_clr_i,
    output logic [EVT_CNT_W-1:0]  evt_cnt_o
);

    typedef enum logic [1:0] {
        ST_ON     = 2'd0,
        ST_GATED  = 2'd1,
        ST_WAKING = 2'd2
    } state_t;

    localparam logic [3:0] WAKE_INIT = 4'(WAKE_LAT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDLE_CNT_W-1:0] r_idle_cnt;
    logic [IDLE_CNT_W-1:0] w_idle_cnt_nxt;
    logic [3:0]            r_wake_cnt;
    logic [3:0]            w_wake_cnt_nxt;
    logic [EVT_CNT_W-1:0]  r_evt_cnt;
    logic                  r_gate_en;
    logic                  r_wake_ack;
    logic                  r_en_lat;
    logic                  w_idle;
    logic                  w_gate_evt;

    assign w_idle = auto_gate_en_i & ~sw_force_on_i & ~busy_i & ~wake_req_i;

    always_comb begin
        w_state_nxt    = r_state;
        w_idle_cnt_nxt = r_idle_cnt;
        w_wake_cnt_nxt = r_wake_cnt;
        w_gate_evt     = 1'b0;
        case (r_state)
            ST_ON: begin
                if (!w_idle) begin
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt >= idle_thresh_i) begin
                    // Threshold is compared live, so lowering it below the
                    // current count gates on the very next idle cycle.
                    w_state_nxt    = ST_GATED;
                    w_idle_cnt_nxt = '0;
                    w_gate_evt     = 1'b1;
                end else if (r_idle_cnt != '1) begin
                    w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                end
            end
            ST_GATED: begin
                w_idle_cnt_nxt = '0;
                if (!w_idle) begin
                    w_state_nxt    = ST_WAKING;
                    w_wake_cnt_nxt = WAKE_INIT;
                end
            end
            ST_WAKING: begin
                // Wake always runs to completion; going idle again here does
                // not abort back to GATED.
                w_idle_cnt_nxt = '0;
                if (r_wake_cnt == 4'd0) begin
                    w_state_nxt = ST_ON;
                end else begin
                    w_wake_cnt_nxt = r_wake_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt    = ST_ON;
                w_idle_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs get their own flops, loaded from the next state, so they are
    // clean register outputs rather than a decode of the state vector.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_ON;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
            r_gate_en  <= 1'b1;
            r_wake_ack <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_wake_cnt <= w_wake_cnt_nxt;
            r_gate_en  <= (w_state_nxt != ST_GATED);
            r_wake_ack <= (w_state_nxt == ST_ON);
        end
    end

    // Clear wins over a same-cycle gate event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_evt_cnt <= '0;
        end else if (evt_clr_i) begin
            r_evt_cnt <= '0;
        end else if (w_gate_evt && (r_evt_cnt != '1)) begin
            r_evt_cnt <= r_evt_cnt + 1'b1;
        end
    end

    // Clock-gating cell: the enable is captured while clk_i is low, so it can
    // only change during the low phase and clk_o never shows a runt pulse.
    always_latch begin
        if (!clk_i) begin
            r_en_lat <= r_gate_en | test_en_i;
        end
    end

    assign clk_o      = clk_i & r_en_lat;
    assign gate_en_o  = r_gate_en;
    assign wake_ack_o = r_wake_ack;
    assign evt_cnt_o  = r_evt_cnt;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
module tb_clk_gate_ctrl;

    localparam int IW = 8;
    localparam int EW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          test_en_i;
    logic          auto_gate_en_i;
    logic          sw_force_on_i;
    logic [IW-1:0] idle_thresh_i;
    logic          busy_i;
    logic          wake_req_i;
    logic          wake_ack_o;
    logic          gate_en_o;
    logic          clk_o;
    logic          evt_clr_i;
    logic [EW-1:0] evt_cnt_o;

    int vectors    = 0;
    int miscompares = 0;

    clk_gate_ctrl #(
        .IDLE_CNT_W (IW),
        .WAKE_LAT   (2),
        .EVT_CNT_W  (EW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .test_en_i      (test_en_i),
        .auto_gate_en_i (auto_gate_en_i),
        .sw_force_on_i  (sw_force_on_i),
        .idle_thresh_i  (idle_thresh_i),
        .busy_i         (busy_i),
        .wake_req_i     (wake_req_i),
        .wake_ack_o     (wake_ack_o),
        .gate_en_o      (gate_en_o),
        .clk_o          (clk_o),
        .evt_clr_i      (evt_clr_i),
        .evt_cnt_o      (evt_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // From ON with threshold 0 and nothing pending: one gate event, then a
    // full wake handshake back to ON.
    task automatic gate_cycle();
        tick();
        wake_req_i = 1'b1;
        tick();
        tick();
        tick();
        wake_req_i = 1'b0;
    endtask

    initial begin
        rst_ni         = 1'b0;
        test_en_i      = 1'b0;
        auto_gate_en_i = 1'b1;
        sw_force_on_i  = 1'b0;
        idle_thresh_i  = 8'd3;
        busy_i         = 1'b0;
        wake_req_i     = 1'b0;
        evt_clr_i      = 1'b0;

        #12;
        chk("rst_gate_en", 32'(gate_en_o), 32'd1);
        chk("rst_wake_ack", 32'(wake_ack_o), 32'd1);
        chk("rst_evt_cnt", 32'(evt_cnt_o), 32'd0);
        rst_ni = 1'b1;

        // Idle run with T=3 gates after the 4th idle edge.
        tick();
        tick();
        tick();
        chk("t1_gate_en_edge3", 32'(gate_en_o), 32'd1);
        chk("t1_clk_running", 32'(clk_o), 32'd1);
        tick();
        chk("t1_gate_en_edge4", 32'(gate_en_o), 32'd0);
        chk("t1_ack_edge4", 32'(wake_ack_o), 32'd0);
        chk("t1_evt_cnt", 32'(evt_cnt_o), 32'd1);
        tick();
        chk("t1_clk_stopped", 32'(clk_o), 32'd0);

        // Wake request: enable after edge n, ack after n+2.
        wake_req_i = 1'b1;
        tick();
        chk("t2_gate_en_n", 32'(gate_en_o), 32'd1);
        chk("t2_ack_n", 32'(wake_ack_o), 32'd0);
        tick();
        chk("t2_ack_n1", 32'(wake_ack_o), 32'd0);
        chk("t2_clk_resumed", 32'(clk_o), 32'd1);
        tick();
        chk("t2_ack_n2", 32'(wake_ack_o), 32'd1);
        chk("t2_gate_en_n2", 32'(gate_en_o), 32'd1);
        wake_req_i = 1'b0;
        // Idle count restarts from 0 after the requester lets go.
        tick();
        tick();
        tick();
        chk("t2_regate_edge3", 32'(gate_en_o), 32'd1);
        tick();
        chk("t2_regate_edge4", 32'(gate_en_o), 32'd0);
        chk("t2_evt_cnt", 32'(evt_cnt_o), 32'd2);

        // Software force-on while gated, then re-gate with T=5.
        sw_force_on_i = 1'b1;
        tick();
        chk("t4_gate_en", 32'(gate_en_o), 32'd1);
        chk("t4_ack_waking", 32'(wake_ack_o), 32'd0);
        tick();
        tick();
        chk("t4_ack_on", 32'(wake_ack_o), 32'd1);
        tick();
        chk("t4_force_holds", 32'(gate_en_o), 32'd1);
        sw_force_on_i = 1'b0;
        idle_thresh_i = 8'd5;
        for (int i = 0; i < 5; i++) tick();
        chk("t4_regate_edge5", 32'(gate_en_o), 32'd1);
        tick();
        chk("t4_regate_edge6", 32'(gate_en_o), 32'd0);
        chk("t4_evt_cnt", 32'(evt_cnt_o), 32'd3);

        // Busy wakes a gated clock, then a busy every 4th cycle never gates.
        busy_i = 1'b1;
        tick();
        chk("t3_busy_wake", 32'(gate_en_o), 32'd1);
        tick();
        tick();
        chk("t3_ack_on", 32'(wake_ack_o), 32'd1);
        for (int i = 0; i < 24; i++) begin
            busy_i = (i % 4 == 3);
            tick();
            chk("t3_never_gates", 32'(gate_en_o), 32'd1);
        end
        chk("t3_evt_cnt", 32'(evt_cnt_o), 32'd3);

        // Lowering the threshold below the current idle count gates next idle edge.
        busy_i = 1'b0;
        tick();
        tick();
        tick();
        chk("live_thresh_before", 32'(gate_en_o), 32'd1);
        idle_thresh_i = 8'd1;
        tick();
        chk("live_thresh_gate", 32'(gate_en_o), 32'd0);
        chk("live_thresh_evt", 32'(evt_cnt_o), 32'd4);

        // Scan enable runs the clock but leaves the FSM gated.
        test_en_i = 1'b1;
        tick();
        chk("te_clk_on", 32'(clk_o), 32'd1);
        chk("te_gate_en", 32'(gate_en_o), 32'd0);
        tick();
        chk("te_clk_on2", 32'(clk_o), 32'd1);
        chk("te_ack", 32'(wake_ack_o), 32'd0);
        test_en_i = 1'b0;
        tick();
        chk("te_off_clk", 32'(clk_o), 32'd0);

        // Asynchronous reset in the middle of WAKING.
        wake_req_i = 1'b1;
        tick();
        tick();
        chk("rst_mid_waking_pre", 32'(wake_ack_o), 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_async_gate_en", 32'(gate_en_o), 32'd1);
        chk("rst_async_ack", 32'(wake_ack_o), 32'd1);
        chk("rst_async_evt", 32'(evt_cnt_o), 32'd0);
        wake_req_i = 1'b0;
        #2;
        rst_ni = 1'b1;

        // Saturation of the event counter at all-ones, then clear priority.
        idle_thresh_i = 8'd0;
        for (int i = 0; i < 254; i++) gate_cycle();
        chk("sat_evt_254", 32'(evt_cnt_o), 32'd254);
        tick();
        chk("sat_evt_255", 32'(evt_cnt_o), 32'd255);
        wake_req_i = 1'b1;
        tick();
        tick();
        tick();
        wake_req_i = 1'b0;
        chk("sat_back_on", 32'(wake_ack_o), 32'd1);
        tick();
        chk("sat_gate_again", 32'(gate_en_o), 32'd0);
        chk("sat_evt_hold", 32'(evt_cnt_o), 32'd255);
        wake_req_i = 1'b1;
        tick();
        tick();
        tick();
        wake_req_i = 1'b0;
        evt_clr_i  = 1'b1;
        tick();
        evt_clr_i  = 1'b0;
        chk("clr_gate_en", 32'(gate_en_o), 32'd0);
        chk("clr_priority", 32'(evt_cnt_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
